rr_mux_4_1_sched: RTL and testbench

Round-robin scheduler and registered 4:1 data selector that sits directly upstream of the 4:1 selection stage. It accepts four valid/ready source channels and chooses one winner per cycle. The winner's data is registered together with its 2-bit source index, which is the select value the downstream 4:1 mux consumes. An optional burst lock lets a winner keep the grant for up to BURST consecutive beats.

---
 rtl/rr_mux_4_1_sched.sv | 104 ++++++++++
 tb/tb_rr_mux_4_1_sched.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/rr_mux_4_1_sched.sv
// Round-robin 4:1 scheduler with registered winner data and select.
// Optional burst lock keeps the grant on one channel for up to BURST beats.
module rr_mux_4_1_sched #(
    parameter int W     = 4,
    parameter int BURST = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     in_valid,
    input  logic [4*W-1:0] in_data,
    output logic [3:0]     in_ready,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic [1:0]     out_sel
);

    logic [1:0]   ptr;
    logic         locked;
    logic [1:0]   lock_ch;
    logic [3:0]   beat_cnt;

    logic         load;
    logic         lock_hit;
    logic [1:0]   start;
    logic [1:0]   gnt;
    logic         gnt_ok;
    logic [1:0]   idx;
    logic [W-1:0] gnt_data;
    logic         burst_end;

    assign load      = !out_valid || out_ready;
    assign lock_hit  = locked && in_valid[lock_ch];
    assign burst_end = ({1'b0, beat_cnt} + 5'd1) == 5'(BURST);

    // A lock whose owner went idle hands the scan to the next channel.
    always_comb begin
        start  = (locked && !in_valid[lock_ch]) ? lock_ch + 2'd1 : ptr;
        gnt    = start;
        gnt_ok = 1'b0;
        idx    = start;
        if (lock_hit) begin
            gnt    = lock_ch;
            gnt_ok = 1'b1;
        end else begin
            for (int k = 3; k >= 0; k--) begin
                idx = start + 2'(k);
                if (in_valid[idx]) begin
                    gnt    = idx;
                    gnt_ok = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt_data = in_data[int'(gnt)*W +: W];
        in_ready = 4'b0000;
        if (load && gnt_ok && !rst)
            in_ready = 4'b0001 << gnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 2'd0;
            ptr       <= 2'd0;
            locked    <= 1'b0;
            lock_ch   <= 2'd0;
            beat_cnt  <= 4'd0;
        end else if (load) begin
            out_valid <= gnt_ok;
            if (gnt_ok) begin
                out_data <= gnt_data;
                out_sel  <= gnt;
            end
            if (lock_hit) begin
                if (burst_end) begin
                    locked   <= 1'b0;
                    beat_cnt <= 4'd0;
                    ptr      <= lock_ch + 2'd1;
                end else begin
                    beat_cnt <= beat_cnt + 4'd1;
                end
            end else begin
                locked   <= 1'b0;
                beat_cnt <= 4'd0;
                if (gnt_ok) begin
                    if (BURST == 1) begin
                        ptr <= gnt + 2'd1;
                    end else begin
                        locked   <= 1'b1;
                        lock_ch  <= gnt;
                        beat_cnt <= 4'd1;
                    end
                end else if (locked) begin
                    ptr <= lock_ch + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_4_1_sched.sv
// Directed bench for rr_mux_4_1_sched: one instance with BURST=1,
// one with BURST=3, each driven from its own stimulus sequence.
module tb_rr_mux_4_1_sched;

    logic        clk = 1'b0;
    logic [15:0] din = 16'hDCBA;

    logic       rst_a, ordy_a, ov_a;
    logic [3:0] vld_a, rdy_a, od_a;
    logic [1:0] os_a;

    logic       rst_b, ordy_b, ov_b;
    logic [3:0] vld_b, rdy_b, od_b;
    logic [1:0] os_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rr_mux_4_1_sched #(.W(4), .BURST(1)) dut_a (
        .clk(clk), .rst(rst_a), .in_valid(vld_a), .in_data(din),
        .in_ready(rdy_a), .out_valid(ov_a), .out_ready(ordy_a),
        .out_data(od_a), .out_sel(os_a)
    );

    rr_mux_4_1_sched #(.W(4), .BURST(3)) dut_b (
        .clk(clk), .rst(rst_b), .in_valid(vld_b), .in_data(din),
        .in_ready(rdy_b), .out_valid(ov_b), .out_ready(ordy_b),
        .out_data(od_b), .out_sel(os_b)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat_a(input string tag, input logic [1:0] sel,
                          input logic [3:0] data);
        step();
        check({tag, "_v"}, 32'(ov_a), 32'd1);
        check({tag, "_s"}, 32'(os_a), 32'(sel));
        check({tag, "_d"}, 32'(od_a), 32'(data));
    endtask

    task automatic beat_b(input string tag, input logic [1:0] sel,
                          input logic [3:0] data);
        step();
        check({tag, "_v"}, 32'(ov_b), 32'd1);
        check({tag, "_s"}, 32'(os_b), 32'(sel));
        check({tag, "_d"}, 32'(od_b), 32'(data));
    endtask

    initial begin
        rst_a = 1'b1; vld_a = 4'b1111; ordy_a = 1'b1;
        rst_b = 1'b1; vld_b = 4'b1111; ordy_b = 1'b1;
        #1;
        check("rst_rdy_a", 32'(rdy_a), 32'h0);
        check("rst_rdy_b", 32'(rdy_b), 32'h0);
        step();
        rst_a = 1'b0;
        #1;
        check("rst_ov", 32'(ov_a), 32'd0);
        check("rst_os", 32'(os_a), 32'd0);
        check("rst_od", 32'(od_a), 32'd0);
        check("first_gnt", 32'(rdy_a), 32'b0001);

        beat_a("rot0", 2'd0, 4'hA);
        check("rot_rdy1", 32'(rdy_a), 32'b0010);
        beat_a("rot1", 2'd1, 4'hB);
        beat_a("rot2", 2'd2, 4'hC);
        beat_a("rot3", 2'd3, 4'hD);
        beat_a("rot4", 2'd0, 4'hA);

        rst_a = 1'b1; vld_a = 4'b1010;
        step();
        rst_a = 1'b0;
        #1;
        check("skip_rdy", 32'(rdy_a), 32'b0010);
        beat_a("skip1", 2'd1, 4'hB);
        check("skip_rdy3", 32'(rdy_a), 32'b1000);
        beat_a("skip3", 2'd3, 4'hD);
        beat_a("skip1b", 2'd1, 4'hB);
        vld_a = 4'b0001;
        #1;
        check("wrap_rdy", 32'(rdy_a), 32'b0001);
        beat_a("wrap0", 2'd0, 4'hA);

        vld_a = 4'b1111; ordy_a = 1'b0;
        #1;
        check("bp_rdy", 32'(rdy_a), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_rdy", 32'(rdy_a), 32'h0);
            check("bp_hold_v", 32'(ov_a), 32'd1);
            check("bp_hold_s", 32'(os_a), 32'd0);
            check("bp_hold_d", 32'(od_a), 32'hA);
        end
        ordy_a = 1'b1;
        #1;
        check("bp_rel_rdy", 32'(rdy_a), 32'b0010);
        beat_a("bp_next", 2'd1, 4'hB);
        beat_a("bp_next2", 2'd2, 4'hC);

        rst_b = 1'b0;
        #1;
        check("b_first", 32'(rdy_b), 32'b0001);
        beat_b("b0a", 2'd0, 4'hA);
        beat_b("b0b", 2'd0, 4'hA);
        beat_b("b0c", 2'd0, 4'hA);
        beat_b("b1a", 2'd1, 4'hB);
        vld_b = 4'b1101;
        #1;
        check("b_drop_rdy", 32'(rdy_b), 32'b0100);
        beat_b("b2a", 2'd2, 4'hC);
        beat_b("b2b", 2'd2, 4'hC);
        rst_b = 1'b1;
        #1;
        check("b_rst_rdy", 32'(rdy_b), 32'h0);
        step();
        check("b_rst_ov", 32'(ov_b), 32'd0);
        rst_b = 1'b0; vld_b = 4'b1111;
        #1;
        check("b_re_rdy", 32'(rdy_b), 32'b0001);
        beat_b("b_re0a", 2'd0, 4'hA);
        beat_b("b_re0b", 2'd0, 4'hA);
        beat_b("b_re0c", 2'd0, 4'hA);
        beat_b("b_re1", 2'd1, 4'hB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
